vld_l2_line_fetch: RTL and testbench
====================================

// Module: vld_l2_line_fetch
// PURPOSE
//  Upstream sequencer and downstream buffer for the L2 DPI-C load model.
//  - Takes one strided vector-load request (base, stride, line count).
//  - Issues one VLEN-bit line read per cycle on the model's enable/paddr port.
//  - Captures each returned line into a credit-protected FIFO.
//  - Presents lines in order to the vector LSU over a valid/ready handshake.
// PARAMETERS
//  VLEN        2048  line width in bits; must match the load model's VLEN
//  MAX_LINES   8     max lines per request
//  FIFO_DEPTH  4     return-buffer entries (power of 2, >=2)
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 synchronous reset, active-high
//  req_valid      in   1                 request valid
//  req_ready      out  1                 request accepted when valid&&ready
//  req_base       in   64                physical byte address of line 0
//  req_stride     in   64                signed byte stride between lines (two's complement)
//  req_nlines     in   $clog2(MAX_LINES+1)  line count, 0..MAX_LINES
//  l2_enable      out  1                 read strobe to load model
//  l2_paddr       out  64                read address to load model
//  l2_load_data   in   VLEN              returned line
//  l2_load_valid  in   1                 returned line valid (1 cycle after enable)
//  out_valid      out  1                 line available
//  out_ready      in   1                 consumer accepts line
//  out_data       out  VLEN              line data
//  out_idx        out  $clog2(MAX_LINES) line index within request
//  out_last       out  1                 final line of request
//  busy           out  1                 request in progress (state != IDLE)
// BEHAVIOUR
//  Reset values: req_ready=0 during rst, then 1 in IDLE; all other outputs 0.
//  FSM states: IDLE, ISSUE, DRAIN.
//   - IDLE: req_ready=1.
//     - Accept with nlines==0: no reads issued, stay in IDLE.
//     - Accept with nlines>0: latch base/stride/nlines, clear issue_cnt, go to ISSUE.
//   - ISSUE: req_ready=0.
//     - l2_enable=1 when issue_cnt<nlines && fifo_cnt+inflight<FIFO_DEPTH.
//     - l2_paddr = base + issue_cnt*stride, truncated mod 2^64 (wrap allowed).
//     - Go to DRAIN in the cycle the last read issues.
//   - DRAIN: no reads issued. Return to IDLE on the cycle the out_last line is popped.
//     The next request can be accepted one cycle later.
//  Load model latency is fixed at 1 cycle.
//   - inflight = number of enables issued whose data has not returned (0 or 1).
//   - l2_load_valid pushes l2_load_data only when inflight>0; otherwise it is ignored.
//  FIFO
//   - push = accepted l2_load_valid; pop = out_valid&&out_ready.
//   - Push and pop in the same cycle are legal at any occupancy, including full.
//   - The credit check uses registered counts only, so overflow is impossible.
//  Output
//   - out_valid = FIFO non-empty. out_data, out_idx and out_last come from the FIFO head.
//   - Head fields are held stable while out_valid && !out_ready.
//   - out_idx counts 0..nlines-1 in issue order. out_last is set when idx==nlines-1.
//  Reset mid-operation: FSM goes to IDLE; FIFO, inflight and counters are cleared.
//   - A late l2_load_valid in the first cycle after reset is dropped (inflight=0).
//  Throughput: with out_ready held high, one line per cycle.
//   - First out_valid appears 2 cycles after request accept.
// TESTING
//  1. base=0x8000_0000, stride=0x100, nlines=3, out_ready=1
//     -> paddr 0x8000_0000/0x8000_0100/0x8000_0200 on consecutive cycles;
//        out_idx 0,1,2; out_last only on idx 2.
//  2. nlines=8, out_ready=0 -> exactly FIFO_DEPTH=4 enables, then l2_enable stays 0;
//     raising out_ready resumes issue; all 8 lines delivered in order.
//  3. stride=-0x100 (0xFFFF_FFFF_FFFF_FF00), base=0x100, nlines=3
//     -> paddr 0x100, 0x0, 0xFFFF_FFFF_FFFF_FF00.
//  4. nlines=0 -> accepted, no l2_enable, no out_valid, busy stays 0.
//  5. rst asserted 1 cycle after the 2nd enable of a 4-line request
//     -> out_valid=0 and busy=0 after reset; the stray l2_load_valid is not pushed;
//        next request (nlines=1) returns exactly one line.
//  6. Random out_ready toggling over 100 requests -> every line delivered once,
//     in order, data matches a reference memory model, no overflow assertion fires.

Source files
------------

// File: rtl/vld_l2_line_fetch.sv
// Strided vector-load sequencer: issues one line read per cycle to the L2 load
// model and buffers the returned lines in a credit-protected FIFO for the LSU.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// ISSUE | issuing line reads while FIFO credit allows
// DRAIN | all reads issued, waiting for the last line to be popped
module vld_l2_line_fetch #(
  parameter int VLEN       = 2048,
  parameter int MAX_LINES  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [63:0]                      req_base,
  input  logic [63:0]                      req_stride,
  input  logic [$clog2(MAX_LINES+1)-1:0]   req_nlines,
  output logic                             l2_enable,
  output logic [63:0]                      l2_paddr,
  input  logic [VLEN-1:0]                  l2_load_data,
  input  logic                             l2_load_valid,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [VLEN-1:0]                  out_data,
  output logic [$clog2(MAX_LINES)-1:0]     out_idx,
  output logic                             out_last,
  output logic                             busy
);

  localparam int NW   = $clog2(MAX_LINES + 1);
  localparam int IDXW = $clog2(MAX_LINES);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [63:0]     addr_q;
  logic [63:0]     stride_q;
  logic [NW-1:0]   nlines_q;
  logic [NW-1:0]   issue_cnt;
  logic            inflight;
  logic [IDXW-1:0] inflight_idx;

  logic [VLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [IDXW-1:0] fifo_idx  [FIFO_DEPTH];
  logic            fifo_last [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic [CW-1:0]   occupancy;

  logic accept;
  logic credit_ok;
  logic push;
  logic pop;
  logic push_last;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);

  // Credit uses registered counts only, so an in-flight read always has a slot.
  assign occupancy = fifo_cnt + CW'(inflight);
  assign credit_ok = (occupancy < CW'(FIFO_DEPTH));

  assign push      = l2_load_valid && inflight;
  assign pop       = out_valid && out_ready;
  assign push_last = (NW'(inflight_idx) == nlines_q - NW'(1));

  always_comb begin
    state_nxt = state;
    l2_enable = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && (req_nlines != '0)) state_nxt = ISSUE;
      end
      ISSUE: begin
        if ((issue_cnt < nlines_q) && credit_ok) begin
          l2_enable = 1'b1;
          if (issue_cnt == nlines_q - NW'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign l2_paddr = l2_enable ? addr_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      stride_q     <= '0;
      nlines_q     <= '0;
      issue_cnt    <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= l2_enable;
      if (accept && (req_nlines != '0)) begin
        addr_q    <= req_base;
        stride_q  <= req_stride;
        nlines_q  <= req_nlines;
        issue_cnt <= '0;
      end else if (l2_enable) begin
        // Running sum replaces base + issue_cnt*stride; wraps mod 2^64.
        addr_q    <= addr_q + stride_q;
        issue_cnt <= issue_cnt + NW'(1);
      end
      if (l2_enable) inflight_idx <= issue_cnt[IDXW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= l2_load_data;
      fifo_idx[wr_ptr]  <= inflight_idx;
      fifo_last[wr_ptr] <= push_last;
    end
  end

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_idx   = out_valid ? fifo_idx[rd_ptr]  : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_cnt == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_vld_l2_line_fetch.sv
// Directed and randomised bench for vld_l2_line_fetch with a 1-cycle load model
// and queue-based expectations for issued addresses and delivered lines.
module tb_vld_l2_line_fetch;

  localparam int VLEN      = 2048;
  localparam int MAX_LINES = 8;
  localparam int NW        = $clog2(MAX_LINES + 1);
  localparam int IDXW      = $clog2(MAX_LINES);

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [63:0]     req_base;
  logic [63:0]     req_stride;
  logic [NW-1:0]   req_nlines;
  logic            l2_enable;
  logic [63:0]     l2_paddr;
  logic [VLEN-1:0] l2_load_data = '0;
  logic            l2_load_valid = 1'b0;
  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] out_data;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic            busy;

  vld_l2_line_fetch #(.VLEN(VLEN), .MAX_LINES(MAX_LINES), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base),
    .req_stride(req_stride), .req_nlines(req_nlines),
    .l2_enable(l2_enable), .l2_paddr(l2_paddr),
    .l2_load_data(l2_load_data), .l2_load_valid(l2_load_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          idx;
    bit          last;
  } exp_line_t;

  logic [63:0] iss_q[$];
  exp_line_t   out_q[$];
  exp_line_t   e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          enable_cnt = 0;
  int          pop_cnt    = 0;
  bit          rand_mode  = 1'b0;

  function automatic logic [VLEN-1:0] line_of(input logic [63:0] a);
    logic [VLEN-1:0] d;
    for (int j = 0; j < VLEN / 64; j++)
      d[j*64 +: 64] = a ^ (64'(j) * 64'h9E37_79B9_7F4A_7C15) ^ {32'(j), 32'h0};
    return d;
  endfunction

  function automatic logic [63:0] fold(input logic [VLEN-1:0] d);
    logic [63:0] x = '0;
    for (int j = 0; j < VLEN / 64; j++)
      x = {x[62:0], x[63]} ^ d[j*64 +: 64];
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // L2 load model: fixed 1-cycle latency, never reset.
  always @(posedge clk) begin
    l2_load_valid <= l2_enable;
    l2_load_data  <= line_of(l2_paddr);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (l2_enable) begin
        enable_cnt++;
        if (iss_q.size() == 0) check("issue_unexpected", 64'(iss_q.size()), 64'd1);
        else check("paddr", l2_paddr, iss_q.pop_front());
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (out_q.size() == 0) check("pop_unexpected", 64'(out_q.size()), 64'd1);
        else begin
          e = out_q.pop_front();
          check("out_idx",  64'(out_idx),  64'(e.idx));
          check("out_last", 64'(out_last), 64'(e.last));
          check("out_data", fold(out_data), fold(line_of(e.addr)));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [63:0] b, input logic [63:0] s, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      iss_q.push_back(b + 64'(i) * s);
      out_q.push_back('{addr: b + 64'(i) * s, idx: i, last: (i == n - 1)});
    end
    req_base   = b;
    req_stride = s;
    req_nlines = NW'(n);
    req_valid  = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      if (req_ready) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    req_valid = 1'b0;
    check("req_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (!busy && !out_valid && out_q.size() == 0 && iss_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("idle_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p0, total;
    rst = 1'b1; req_valid = 1'b0; req_base = '0; req_stride = '0;
    req_nlines = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_enable",    64'(l2_enable), 64'd0);
    check("rst_paddr",     l2_paddr,       64'd0);
    rst = 1'b0;
    step();
    check("idle_req_ready", 64'(req_ready), 64'd1);

    // 1: unit stride-ish sequence, one line per cycle
    out_ready = 1'b1;
    send_req(64'h8000_0000, 64'h100, 3);
    check("t1_en_c1", 64'(l2_enable), 64'd1);
    check("t1_pa_c1", l2_paddr, 64'h8000_0000);
    check("t1_busy",  64'(busy), 64'd1);
    check("t1_ready", 64'(req_ready), 64'd0);
    step();
    check("t1_pa_c2", l2_paddr, 64'h8000_0100);
    check("t1_ov_c2", 64'(out_valid), 64'd0);
    step();
    check("t1_pa_c3",  l2_paddr, 64'h8000_0200);
    check("t1_ov_c3",  64'(out_valid), 64'd1);
    check("t1_idx_c3", 64'(out_idx), 64'd0);
    step();
    check("t1_en_c4",   64'(l2_enable), 64'd0);
    check("t1_idx_c4",  64'(out_idx), 64'd1);
    step();
    check("t1_last_c5", 64'(out_last), 64'd1);
    step();
    check("t1_busy_c6", 64'(busy), 64'd0);
    wait_idle(50);

    // 2: consumer stalled, credit limits issue to FIFO depth
    e0 = enable_cnt;
    out_ready = 1'b0;
    send_req(64'h1000_0000, 64'h40, 8);
    repeat (10) step();
    check("t2_credit_enables", 64'(enable_cnt - e0), 64'd4);
    check("t2_enable_held",    64'(l2_enable), 64'd0);
    check("t2_head_valid",     64'(out_valid), 64'd1);
    check("t2_head_idx",       64'(out_idx), 64'd0);
    check("t2_head_data",      fold(out_data), fold(line_of(64'h1000_0000)));
    out_ready = 1'b1;
    wait_idle(100);
    check("t2_total_enables",  64'(enable_cnt - e0), 64'd8);

    // 3: negative stride wrapping below zero
    send_req(64'h100, 64'hFFFF_FFFF_FFFF_FF00, 3);
    check("t3_pa0", l2_paddr, 64'h100);
    step();
    check("t3_pa1", l2_paddr, 64'h0);
    step();
    check("t3_pa2", l2_paddr, 64'hFFFF_FFFF_FFFF_FF00);
    wait_idle(50);

    // 4: zero-line request
    e0 = enable_cnt;
    send_req(64'h5000, 64'h40, 0);
    check("t4_busy",  64'(busy), 64'd0);
    check("t4_ready", 64'(req_ready), 64'd1);
    repeat (4) step();
    check("t4_busy_later", 64'(busy), 64'd0);
    check("t4_no_valid",   64'(out_valid), 64'd0);
    check("t4_no_enable",  64'(enable_cnt - e0), 64'd0);

    // 5: reset mid-request, stray return must be dropped
    out_ready = 1'b0;
    send_req(64'h2000_0000, 64'h80, 4);
    step();
    step();
    rst = 1'b1;
    iss_q.delete();
    out_q.delete();
    check("t5_ready_in_rst", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;
    check("t5_valid_after", 64'(out_valid), 64'd0);
    check("t5_busy_after",  64'(busy), 64'd0);
    step();
    check("t5_stray_dropped", 64'(out_valid), 64'd0);
    check("t5_ready_idle",    64'(req_ready), 64'd1);
    e0 = enable_cnt;
    p0 = pop_cnt;
    out_ready = 1'b1;
    send_req(64'h3000_0000, 64'h40, 1);
    wait_idle(50);
    check("t5_one_enable", 64'(enable_cnt - e0), 64'd1);
    check("t5_one_line",   64'(pop_cnt - p0), 64'd1);

    // 6: random requests with random back-pressure
    p0 = pop_cnt;
    total = 0;
    rand_mode = 1'b1;
    for (int r = 0; r < 100; r++) begin
      int n = int'($urandom_range(0, MAX_LINES));
      total += n;
      send_req({$urandom, $urandom}, {$urandom, $urandom}, n);
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    wait_idle(3000);
    check("t6_lines_delivered", 64'(pop_cnt - p0), 64'(total));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
